seg_display_decoder: RTL and testbench
======================================

Name: seg_display_decoder

Overview:
- Receive side of the two-digit seven-segment display path. Takes a tens/ones pair of seven-segment codes and recovers the original 5-bit binary value (0..31).
- Used for loopback self-check of the display path and for decoding captured display state back into processor-visible values.
- Decoding is multi-cycle: one digit-lookup cycle, then iterative add-10 accumulation for the tens digit.
- Uses val/rdy handshakes on both input and output.

Parameters:
SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0; 0 = lit when bit is 1 (all codes below are inverted).

Ports:
clk       input   1  clock; all state updates on rising edge
rst       input   1  asynchronous, active-high reset
seg_tens  input   7  tens-digit code; bit0 = segment a ... bit6 = segment g
seg_ones  input   7  ones-digit code; same bit order
in_val    input   1  input pair valid
in_rdy    output  1  block can accept a pair
out       output  5  decoded binary value
err       output  1  decode failed; qualified by out_val
out_val   output  1  out/err valid
out_rdy   input   1  consumer accepts result

Behaviour:
- Reset (async, rst=1): state=IDLE, in_rdy=1, out_val=0, out=0, err=0, all internal registers cleared. Reset mid-operation discards the transaction in flight; no output is produced for it.
- Digit codes with SEG_ACTIVE_LOW=1, written g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other pattern, including blank, is invalid.
- IDLE:
  - in_rdy=1, out_val=0.
  - On in_val=1, capture seg_tens and seg_ones into registers and go to DECODE.
  - No combinational path from inputs to outputs.
- DECODE (one cycle, in_rdy=0):
  - Map both registered codes to digits.
  - err_next=1 if either code is invalid, tens>3, or (tens==3 and ones>1).
  - acc (6-bit) <= ones; cnt (2-bit) <= tens.
  - If err_next or tens==0, go to DONE; else go to ACCUM.
- ACCUM (one cycle per tens count):
  - Each cycle: acc<=acc+10, cnt<=cnt-1.
  - When cnt==1 at the edge, go to DONE.
  - acc never exceeds 31 in this state because overflow is rejected in DECODE.
- DONE:
  - out_val=1; out=acc[4:0], or out=0 when err=1.
  - Outputs stay stable while out_rdy=0, for arbitrary backpressure.
  - On out_rdy=1, go to IDLE; out_val drops the next cycle.
  - in_rdy is not asserted in the same cycle as out_val (no bypass).
- Latency, with the input handshake in cycle T:
  - out_val=1 in cycle T+2+tens for valid input.
  - out_val=1 in cycle T+2 on error or when tens==0.
- Throughput: at most one pair in flight. The next accept is possible in the cycle after the out handshake.
- in_val while not in IDLE is ignored; the source holds data until in_rdy=1.
- out, err and out_val are driven from registers only.

Test Plan:
- Reset, then codes "0","0" with in_val pulse at T -> out_val=1 at T+2, out=0, err=0; out_rdy=1 -> IDLE, in_rdy=1 at T+3.
- Codes "2","7" -> out_val at T+4, out=27, err=0; "3","1" -> out_val at T+5, out=31.
- Codes "3","5" -> out_val at T+2, err=1, out=0. Codes "4","0" -> err=1 at T+2. seg_ones=1111111 (blank) -> err=1 at T+2.
- Codes "1","9" with out_rdy held 0 for 4 cycles -> out=19, out_val=1 stable throughout; in_rdy=0 until the cycle after out_rdy=1.
- Start "3","0", assert rst during ACCUM -> out_val=0 immediately, in_rdy=1; next "0","5" -> out=5 at T+2.
- Sweep all 32 values from the display-path encoder through this block -> out equals encoder input and err=0 every time.

Source files
------------

// File: rtl/seg_display_decoder_if.sv
// Handshake bundle between a display-code source and the decoder, and from the
// decoder to the consumer of the recovered binary value.
interface seg_display_decoder_if;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
  logic       in_val;
  logic       in_rdy;
  logic [4:0] out;
  logic       err;
  logic       out_val;
  logic       out_rdy;

  modport master (
    output seg_tens, seg_ones, in_val, out_rdy,
    input  in_rdy, out, err, out_val
  );

  modport slave (
    input  seg_tens, seg_ones, in_val, out_rdy,
    output in_rdy, out, err, out_val
  );
endinterface

// File: rtl/seg_display_decoder.sv
// Recovers a 0..31 binary value from a tens/ones pair of seven-segment codes:
// one lookup cycle, then one add-10 cycle per tens count.
module seg_display_decoder #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_display_decoder_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] ACCUM  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0] state;
  logic [6:0] tens_code;
  logic [6:0] ones_code;
  logic [5:0] acc;
  logic [1:0] cnt;
  logic [4:0] out_q;
  logic       err_q;
  logic       out_val_q;
  logic       in_rdy_q;

  // Returns {valid, digit}; the code is normalised to active-low form first.
  function automatic logic [4:0] seg_lookup(input logic [6:0] code);
    logic [6:0] c;
    c = SEG_ACTIVE_LOW ? code : ~code;
    case (c)
      7'h40:   seg_lookup = {1'b1, 4'd0};
      7'h79:   seg_lookup = {1'b1, 4'd1};
      7'h24:   seg_lookup = {1'b1, 4'd2};
      7'h30:   seg_lookup = {1'b1, 4'd3};
      7'h19:   seg_lookup = {1'b1, 4'd4};
      7'h12:   seg_lookup = {1'b1, 4'd5};
      7'h02:   seg_lookup = {1'b1, 4'd6};
      7'h78:   seg_lookup = {1'b1, 4'd7};
      7'h00:   seg_lookup = {1'b1, 4'd8};
      7'h10:   seg_lookup = {1'b1, 4'd9};
      default: seg_lookup = 5'd0;
    endcase
  endfunction

  logic [4:0] tens_lk;
  logic [4:0] ones_lk;
  logic [3:0] tens_dig;
  logic [3:0] ones_dig;
  logic       err_next;
  logic [5:0] acc_next;

  always_comb begin
    tens_lk  = seg_lookup(tens_code);
    ones_lk  = seg_lookup(ones_code);
    tens_dig = tens_lk[3:0];
    ones_dig = ones_lk[3:0];
    // Anything above 31 is rejected here, so ACCUM can never overflow 5 bits.
    err_next = !tens_lk[4] || !ones_lk[4] || (tens_dig > 4'd3) ||
               ((tens_dig == 4'd3) && (ones_dig > 4'd1));
    acc_next = acc + 6'd10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tens_code <= '0;
      ones_code <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
      out_val_q <= 1'b0;
      in_rdy_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_val) begin
            tens_code <= bus.seg_tens;
            ones_code <= bus.seg_ones;
            in_rdy_q  <= 1'b0;
            state     <= DECODE;
          end
        end
        DECODE: begin
          acc   <= {2'b00, ones_dig};
          cnt   <= tens_dig[1:0];
          err_q <= err_next;
          if (err_next || (tens_dig == 4'd0)) begin
            out_q     <= err_next ? 5'd0 : {1'b0, ones_dig};
            out_val_q <= 1'b1;
            state     <= DONE;
          end else begin
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_next;
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            out_q     <= acc_next[4:0];
            out_val_q <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Result is held unchanged for as long as the consumer stalls.
          if (bus.out_rdy) begin
            out_val_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_rdy  = in_rdy_q;
  assign bus.out     = out_q;
  assign bus.err     = err_q;
  assign bus.out_val = out_val_q;

endmodule

// File: tb/tb_seg_display_decoder.sv
// Directed bench for seg_display_decoder: reset, decode latency, error cases,
// backpressure, mid-operation reset and a full 0..31 sweep.
module tb_seg_display_decoder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seg_display_decoder_if bus();

  seg_display_decoder #(.SEG_ACTIVE_LOW(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Active-low display encoding of one decimal digit, g..a.
  function automatic logic [6:0] enc_digit(input int d);
    case (d)
      0: enc_digit = 7'b1000000;
      1: enc_digit = 7'b1111001;
      2: enc_digit = 7'b0100100;
      3: enc_digit = 7'b0110000;
      4: enc_digit = 7'b0011001;
      5: enc_digit = 7'b0010010;
      6: enc_digit = 7'b0000010;
      7: enc_digit = 7'b1111000;
      8: enc_digit = 7'b0000000;
      9: enc_digit = 7'b0010000;
      default: enc_digit = 7'b1111111;
    endcase
  endfunction

  // Presents a pair for exactly one accepting edge; returns at the negedge after it.
  task automatic send(input logic [6:0] t, input logic [6:0] o);
    int w;
    w = 0;
    while (!bus.in_rdy && w < 50) begin
      @(negedge clk);
      w++;
    end
    bus.seg_tens = t;
    bus.seg_ones = o;
    bus.in_val   = 1'b1;
    @(negedge clk);
    bus.in_val   = 1'b0;
  endtask

  // Latency counted in cycles from the accept cycle; capped so a hang shows as a bad latency.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_val && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b want 1", bus.in_rdy); end
    checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val: got %b want 0", bus.out_val); end
    checks++; if (bus.out !== 5'd0) begin errors++; $display("FAIL reset_out: got %0d want 0", bus.out); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero;
    int lat;
    send(enc_digit(0), enc_digit(0));
    wait_out(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL zero_latency: got %0d want 2", lat); end
    checks++; if (bus.out !== 5'd0) begin errors++; $display("FAIL zero_out: got %0d want 0", bus.out); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL zero_err: got %b want 0", bus.err); end
    checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL zero_no_bypass: in_rdy got %b want 0", bus.in_rdy); end
    bus.out_rdy = 1'b1;
    @(negedge clk);
    bus.out_rdy = 1'b0;
    checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL zero_in_rdy_t3: got %b want 1", bus.in_rdy); end
    checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL zero_out_val_drop: got %b want 0", bus.out_val); end
  endtask

  task automatic test_valid;
    int td[3]  = '{2, 3, 1};
    int od[3]  = '{7, 1, 4};
    int lat;
    int expv;
    for (int i = 0; i < 3; i++) begin
      expv = td[i] * 10 + od[i];
      send(enc_digit(td[i]), enc_digit(od[i]));
      wait_out(lat);
      checks++; if (lat !== 2 + td[i]) begin errors++; $display("FAIL valid_latency %0d: got %0d want %0d", expv, lat, 2 + td[i]); end
      checks++; if (bus.out !== expv[4:0]) begin errors++; $display("FAIL valid_out %0d: got %0d want %0d", expv, bus.out, expv); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL valid_err %0d: got %b want 0", expv, bus.err); end
      bus.out_rdy = 1'b1;
      @(negedge clk);
      bus.out_rdy = 1'b0;
    end
  endtask

  task automatic test_errors;
    logic [6:0] tc[4];
    logic [6:0] oc[4];
    int lat;
    tc[0] = enc_digit(3);  oc[0] = enc_digit(5);
    tc[1] = enc_digit(4);  oc[1] = enc_digit(0);
    tc[2] = enc_digit(1);  oc[2] = 7'b1111111;
    tc[3] = 7'b0101010;    oc[3] = enc_digit(2);
    for (int i = 0; i < 4; i++) begin
      send(tc[i], oc[i]);
      wait_out(lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL err_latency case %0d: got %0d want 2", i, lat); end
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_flag case %0d: got %b want 1", i, bus.err); end
      checks++; if (bus.out !== 5'd0) begin errors++; $display("FAIL err_out case %0d: got %0d want 0", i, bus.out); end
      bus.out_rdy = 1'b1;
      @(negedge clk);
      bus.out_rdy = 1'b0;
    end
  endtask

  task automatic test_backpressure;
    int lat;
    send(enc_digit(1), enc_digit(9));
    wait_out(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL bp_latency: got %0d want 3", lat); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.out_val !== 1'b1) begin errors++; $display("FAIL bp_out_val cycle %0d: got %b want 1", i, bus.out_val); end
      checks++; if (bus.out !== 5'd19) begin errors++; $display("FAIL bp_out cycle %0d: got %0d want 19", i, bus.out); end
      checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy cycle %0d: got %b want 0", i, bus.in_rdy); end
    end
    bus.out_rdy = 1'b1;
    @(negedge clk);
    bus.out_rdy = 1'b0;
    checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_in_rdy: got %b want 1", bus.in_rdy); end
    checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL bp_release_out_val: got %b want 0", bus.out_val); end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit seen;
    send(enc_digit(3), enc_digit(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL rst_mid_out_val: got %b want 0", bus.out_val); end
    checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_in_rdy: got %b want 1", bus.in_rdy); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.out_val) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_discard: out_val seen %b want 0", seen); end
    send(enc_digit(0), enc_digit(5));
    wait_out(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rst_mid_next_latency: got %0d want 2", lat); end
    checks++; if (bus.out !== 5'd5) begin errors++; $display("FAIL rst_mid_next_out: got %0d want 5", bus.out); end
    bus.out_rdy = 1'b1;
    @(negedge clk);
    bus.out_rdy = 1'b0;
  endtask

  task automatic test_sweep;
    int lat;
    logic [4:0] v;
    for (int n = 0; n < 32; n++) begin
      v = n[4:0];
      send(enc_digit(n / 10), enc_digit(n % 10));
      wait_out(lat);
      checks++; if (lat !== 2 + n / 10) begin errors++; $display("FAIL sweep_latency %0d: got %0d want %0d", n, lat, 2 + n / 10); end
      checks++; if (bus.out !== v) begin errors++; $display("FAIL sweep_out %0d: got %0d want %0d", n, bus.out, v); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL sweep_err %0d: got %b want 0", n, bus.err); end
      bus.out_rdy = 1'b1;
      @(negedge clk);
      bus.out_rdy = 1'b0;
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.seg_tens = '0;
    bus.seg_ones = '0;
    bus.in_val   = 1'b0;
    bus.out_rdy  = 1'b0;
    @(negedge clk);
    test_reset();
    test_zero();
    test_valid();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
